display_update_tracker: RTL and testbench

- Sits directly downstream of the register-file display wrapper, between it and the LCD painter.
- Owns the display_number scan: steps through entries 1..NUM_ENTRIES and captures the returned display_valid/display_name/display_value for each one.
- Caches every entry and marks an entry dirty only when its content changes.
- Streams changed entries to the painter over a valid/ready handshake, so the painter redraws only changed blocks.

---
 rtl/display_update_tracker.sv | 220 ++++++++++++++++++++++
 tb/tb_display_update_tracker.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_update_tracker.sv
// display_update_tracker
//
// Sits between the register-file display wrapper and the LCD painter. It scans
// display blocks 1..NUM_ENTRIES, caches what the producer returns for each block,
// and streams only the blocks whose content changed to the painter.
//
// Ports:
//   clk, reset          system clock; asynchronous active-high reset
//   display_number      block number requested from the producer (1..NUM_ENTRIES)
//   display_valid/name/value
//                       producer response, registered: belongs to the previous
//                       cycle's display_number
//   force_refresh       one-cycle pulse, re-sends every currently valid block
//   upd_valid/upd_ready handshake towards the painter
//   upd_number/blank/name/value
//                       presented update; blank=1 erases the block (name/value zero)
//   scan_wrap           pulses when the sample of the last block is captured
module display_update_tracker #(
    parameter int unsigned NUM_ENTRIES = 38,
    parameter int unsigned NAME_W      = 40,
    parameter int unsigned VALUE_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    output logic [5:0]         display_number,
    input  logic               display_valid,
    input  logic [NAME_W-1:0]  display_name,
    input  logic [VALUE_W-1:0] display_value,
    input  logic               force_refresh,
    output logic               upd_valid,
    input  logic               upd_ready,
    output logic [5:0]         upd_number,
    output logic               upd_blank,
    output logic [NAME_W-1:0]  upd_name,
    output logic [VALUE_W-1:0] upd_value,
    output logic               scan_wrap
);

    localparam logic [5:0] LastNum = 6'(NUM_ENTRIES);

    logic [5:0]           disp_num_q;
    logic [5:0]           sample_num_q;
    logic                 sample_ok_q;
    logic [NUM_ENTRIES:1] cache_valid_q;
    logic [NUM_ENTRIES:1] dirty_q;
    logic [NUM_ENTRIES:1] dirty_d;
    logic [NUM_ENTRIES:1] mark;
    logic [NAME_W-1:0]    cache_name_q  [1:NUM_ENTRIES];
    logic [VALUE_W-1:0]   cache_value_q [1:NUM_ENTRIES];

    logic                 upd_valid_q;
    logic [5:0]           upd_number_q;
    logic                 upd_blank_q;
    logic [NAME_W-1:0]    upd_name_q;
    logic [VALUE_W-1:0]   upd_value_q;
    logic [5:0]           ptr_q;
    // Presented entry was re-marked while in flight; keep it dirty on accept.
    logic                 redirty_q;
    logic                 redirty_d;

    logic                 sel_found;
    logic                 hi_found;
    logic [5:0]           hi_idx;
    logic [5:0]           lo_idx;
    logic [5:0]           sel_idx;
    logic                 sel_valid;
    logic [NAME_W-1:0]    sel_name;
    logic [VALUE_W-1:0]   sel_value;
    logic                 mark_at_sel;
    logic                 mark_at_upd;
    logic                 load;
    logic                 accept;

    // Scan counter plus the one-cycle delayed tag of the returned sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_num_q   <= 6'd1;
            sample_num_q <= '0;
            sample_ok_q  <= 1'b0;
        end else begin
            disp_num_q   <= (disp_num_q == LastNum) ? 6'd1 : disp_num_q + 6'd1;
            sample_num_q <= disp_num_q;
            sample_ok_q  <= 1'b1;
        end
    end

    // Entries that become dirty this cycle (content change or forced refresh).
    always_comb begin
        mark = '0;
        for (int i = 1; i <= int'(NUM_ENTRIES); i++) begin
            if (sample_ok_q && int'(sample_num_q) == i) begin
                if (display_valid) begin
                    mark[i] = !cache_valid_q[i] || (display_name != cache_name_q[i]) ||
                              (display_value != cache_value_q[i]);
                end else begin
                    mark[i] = cache_valid_q[i];
                end
            end
            if (force_refresh && cache_valid_q[i]) begin
                mark[i] = 1'b1;
            end
        end
    end

    // Round-robin pick: lowest dirty index above the pointer, else lowest overall.
    always_comb begin
        sel_found = 1'b0;
        hi_found  = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int i = 1; i <= int'(NUM_ENTRIES); i++) begin
            if (dirty_q[i]) begin
                if (!sel_found) begin
                    sel_found = 1'b1;
                    lo_idx    = 6'(i);
                end
                if (!hi_found && 6'(i) > ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = 6'(i);
                end
            end
        end
        sel_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_valid   = 1'b0;
        sel_name    = '0;
        sel_value   = '0;
        mark_at_sel = 1'b0;
        mark_at_upd = 1'b0;
        for (int i = 1; i <= int'(NUM_ENTRIES); i++) begin
            if (6'(i) == sel_idx) begin
                sel_valid   = cache_valid_q[i];
                sel_name    = cache_name_q[i];
                sel_value   = cache_value_q[i];
                mark_at_sel = mark[i];
            end
            if (6'(i) == upd_number_q) begin
                mark_at_upd = mark[i];
            end
        end
    end

    assign load   = !upd_valid_q && sel_found;
    assign accept = upd_valid_q && upd_ready;

    always_comb begin
        dirty_d = dirty_q | mark;
        if (accept) begin
            for (int i = 1; i <= int'(NUM_ENTRIES); i++) begin
                if (6'(i) == upd_number_q) begin
                    dirty_d[i] = mark[i] | redirty_q;
                end
            end
        end
        redirty_d = redirty_q;
        if (load) begin
            redirty_d = mark_at_sel;
        end else if (accept) begin
            redirty_d = 1'b0;
        end else if (upd_valid_q) begin
            redirty_d = redirty_q | mark_at_upd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cache_valid_q <= '0;
            dirty_q       <= '0;
            for (int i = 1; i <= int'(NUM_ENTRIES); i++) begin
                cache_name_q[i]  <= '0;
                cache_value_q[i] <= '0;
            end
        end else begin
            dirty_q <= dirty_d;
            for (int i = 1; i <= int'(NUM_ENTRIES); i++) begin
                if (sample_ok_q && int'(sample_num_q) == i) begin
                    cache_valid_q[i] <= display_valid;
                    cache_name_q[i]  <= display_name;
                    cache_value_q[i] <= display_value;
                end
            end
        end
    end

    // Update register: loaded from the cache snapshot, frozen until accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_valid_q  <= 1'b0;
            upd_number_q <= '0;
            upd_blank_q  <= 1'b0;
            upd_name_q   <= '0;
            upd_value_q  <= '0;
            ptr_q        <= '0;
            redirty_q    <= 1'b0;
        end else begin
            redirty_q <= redirty_d;
            if (load) begin
                upd_valid_q  <= 1'b1;
                upd_number_q <= sel_idx;
                upd_blank_q  <= !sel_valid;
                upd_name_q   <= sel_valid ? sel_name : '0;
                upd_value_q  <= sel_valid ? sel_value : '0;
                ptr_q        <= sel_idx;
            end else if (accept) begin
                upd_valid_q <= 1'b0;
            end
        end
    end

    assign display_number = disp_num_q;
    assign upd_valid      = upd_valid_q;
    assign upd_number     = upd_number_q;
    assign upd_blank      = upd_blank_q;
    assign upd_name       = upd_name_q;
    assign upd_value      = upd_value_q;
    assign scan_wrap      = sample_ok_q && (sample_num_q == LastNum);

endmodule

// File: tb/tb_display_update_tracker.sv
// Bench for display_update_tracker: a registered producer model serves a content
// table, a painter model keeps the drawn screen, and directed plus randomized
// content changes are checked against the expected number of redraws and the
// final screen contents.
module tb_display_update_tracker;

    localparam int N = 38;
    localparam logic [39:0] Reg00 = 40'h5245473030;
    localparam logic [39:0] Reg02 = 40'h5245473032;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  display_number;
    logic        display_valid;
    logic [39:0] display_name;
    logic [31:0] display_value;
    logic        force_refresh;
    logic        upd_valid;
    logic        upd_ready;
    logic [5:0]  upd_number;
    logic        upd_blank;
    logic [39:0] upd_name;
    logic [31:0] upd_value;
    logic        scan_wrap;

    always #5 clk = ~clk;

    display_update_tracker dut (
        .clk            (clk),
        .reset          (reset),
        .display_number (display_number),
        .display_valid  (display_valid),
        .display_name   (display_name),
        .display_value  (display_value),
        .force_refresh  (force_refresh),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_number     (upd_number),
        .upd_blank      (upd_blank),
        .upd_name       (upd_name),
        .upd_value      (upd_value),
        .scan_wrap      (scan_wrap)
    );

    int compared   = 0;
    int mismatched = 0;
    int ready_mode = 0;  // 0: always ready, 1: random, 2: held low

    // Content served by the producer, and what the painter has drawn.
    logic        tb_valid  [0:63];
    logic [39:0] tb_name   [0:63];
    logic [31:0] tb_value  [0:63];
    logic        scr_valid [0:63];
    logic [39:0] scr_name  [0:63];
    logic [31:0] scr_value [0:63];

    int          accepts;
    int          blank_accepts;
    logic [5:0]  last_num;
    logic        last_blank;
    logic [39:0] last_name;
    logic [31:0] last_value;
    logic [5:0]  rise_dn;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [72:0] eff(input int i);
        return tb_valid[i] ? {1'b1, tb_name[i], tb_value[i]} : 73'd0;
    endfunction

    function automatic int count_valid();
        int c = 0;
        for (int i = 1; i <= N; i++) if (tb_valid[i]) c++;
        return c;
    endfunction

    task automatic check_screen(input string tag);
        for (int i = 1; i <= N; i++) begin
            check($sformatf("%s_vis%0d", tag, i), 64'(scr_valid[i]), 64'(tb_valid[i]));
            if (tb_valid[i]) begin
                check($sformatf("%s_name%0d", tag, i), 64'(scr_name[i]), 64'(tb_name[i]));
                check($sformatf("%s_val%0d", tag, i), 64'(scr_value[i]), 64'(tb_value[i]));
            end
        end
    endtask

    task automatic clear_screen();
        for (int i = 0; i < 64; i++) begin
            scr_valid[i] = 1'b0;
            scr_name[i]  = '0;
            scr_value[i] = '0;
        end
    endtask

    task automatic pulse_refresh();
        force_refresh = 1'b1;
        step(1);
        force_refresh = 1'b0;
    endtask

    // Producer: registers the table entry for the requested block.
    initial begin
        display_valid = 1'b0;
        display_name  = '0;
        display_value = '0;
        forever begin
            @(posedge clk);
            display_valid <= tb_valid[display_number];
            display_name  <= tb_name[display_number];
            display_value <= tb_value[display_number];
        end
    end

    // Painter ready.
    initial begin
        upd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       upd_ready = 1'b1;
                1:       upd_ready = 1'($urandom_range(0, 1));
                default: upd_ready = 1'b0;
            endcase
        end
    end

    // Painter / protocol monitor.
    logic        armed = 1'b0;
    logic        prev_hold = 1'b0;
    logic        prev_acc = 1'b0;
    logic        prev_valid = 1'b0;
    logic [5:0]  prev_dn;
    logic [5:0]  h_num;
    logic        h_blank;
    logic [39:0] h_name;
    logic [31:0] h_value;

    always @(negedge clk) begin
        if (reset) begin
            armed      = 1'b0;
            prev_hold  = 1'b0;
            prev_acc   = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (armed) begin
                check("disp_seq", 64'(display_number),
                      64'((prev_dn == 6'(N)) ? 6'd1 : prev_dn + 6'd1));
                check("scan_wrap", 64'(scan_wrap), 64'(prev_dn == 6'(N)));
                if (prev_hold) begin
                    check("hold_valid", 64'(upd_valid), 64'd1);
                    check("hold_num", 64'(upd_number), 64'(h_num));
                    check("hold_blank", 64'(upd_blank), 64'(h_blank));
                    check("hold_name", 64'(upd_name), 64'(h_name));
                    check("hold_value", 64'(upd_value), 64'(h_value));
                end
                if (prev_acc) check("gap", 64'(upd_valid), 64'd0);
            end
            if (upd_valid) begin
                check("upd_range", 64'(upd_number >= 6'd1 && upd_number <= 6'(N)), 64'd1);
                if (upd_blank) begin
                    check("blank_name", 64'(upd_name), 64'd0);
                    check("blank_value", 64'(upd_value), 64'd0);
                end
                if (!prev_valid) rise_dn = display_number;
                if (upd_ready) begin
                    accepts++;
                    if (upd_blank) blank_accepts++;
                    scr_valid[upd_number] = !upd_blank;
                    scr_name[upd_number]  = upd_name;
                    scr_value[upd_number] = upd_value;
                    last_num   = upd_number;
                    last_blank = upd_blank;
                    last_name  = upd_name;
                    last_value = upd_value;
                end
            end
            prev_hold  = upd_valid && !upd_ready;
            prev_acc   = upd_valid && upd_ready;
            prev_valid = upd_valid;
            h_num      = upd_number;
            h_blank    = upd_blank;
            h_name     = upd_name;
            h_value    = upd_value;
            prev_dn    = display_number;
            armed      = 1'b1;
        end
    end

    initial begin
        int          n;
        int          exp_cnt;
        int          idx;
        logic [63:0] r64;
        logic [72:0] old_c;
        logic        picked [0:63];

        reset         = 1'b1;
        force_refresh = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tb_valid[i] = 1'b0;
            tb_name[i]  = '0;
            tb_value[i] = '0;
        end
        clear_screen();
        for (int i = 7; i <= N; i++) begin
            tb_valid[i] = 1'b1;
            tb_name[i]  = Reg00;
        end

        // Reset state.
        step(3);
        check("rst_dn", 64'(display_number), 64'd1);
        check("rst_valid", 64'(upd_valid), 64'd0);
        check("rst_num", 64'(upd_number), 64'd0);
        check("rst_blank", 64'(upd_blank), 64'd0);
        check("rst_name", 64'(upd_name), 64'd0);
        check("rst_value", 64'(upd_value), 64'd0);
        check("rst_wrap", 64'(scan_wrap), 64'd0);

        // First pass: blocks 7..38 drawn, 1..6 untouched.
        reset = 1'b0;
        accepts = 0;
        blank_accepts = 0;
        step(300);
        check("t1_count", 64'(accepts), 64'd32);
        check("t1_blanks", 64'(blank_accepts), 64'd0);
        check_screen("t1");

        // Steady content: no further traffic.
        accepts = 0;
        step(3 * N + 5);
        check("t2_count", 64'(accepts), 64'd0);
        check("t2_valid", 64'(upd_valid), 64'd0);

        // Single value change.
        accepts = 0;
        tb_value[9] = 32'hDEADBEEF;
        step(150);
        check("t3_count", 64'(accepts), 64'd1);
        check("t3_num", 64'(last_num), 64'd9);
        check("t3_value", 64'(last_value), 64'hDEADBEEF);
        check("t3_blank", 64'(last_blank), 64'd0);
        check("t3_latency", 64'(rise_dn), 64'd12);

        // Block 2 appears, then goes invalid.
        accepts = 0;
        tb_valid[2] = 1'b1;
        tb_name[2]  = Reg02;
        tb_value[2] = 32'd5;
        step(150);
        check("t4a_count", 64'(accepts), 64'd1);
        check("t4a_num", 64'(last_num), 64'd2);
        accepts = 0;
        tb_valid[2] = 1'b0;
        step(150);
        check("t4_count", 64'(accepts), 64'd1);
        check("t4_num", 64'(last_num), 64'd2);
        check("t4_blank", 64'(last_blank), 64'd1);
        check("t4_name", 64'(last_name), 64'd0);
        check("t4_value", 64'(last_value), 64'd0);
        check("t4_latency", 64'(rise_dn), 64'd5);
        check_screen("t4");

        // Stall while the presented block changes again.
        ready_mode = 2;
        step(2);
        accepts = 0;
        tb_value[9] = 32'd1;
        n = 0;
        while (!upd_valid && n < 200) begin
            step(1);
            n++;
        end
        check("t5_present", 64'(upd_valid), 64'd1);
        check("t5_num", 64'(upd_number), 64'd9);
        check("t5_value1", 64'(upd_value), 64'd1);
        tb_value[9] = 32'd2;
        step(100);
        check("t5_still", 64'(upd_valid), 64'd1);
        check("t5_held", 64'(upd_value), 64'd1);
        ready_mode = 0;
        step(150);
        check("t5_count", 64'(accepts), 64'd2);
        check("t5_num2", 64'(last_num), 64'd9);
        check("t5_value2", 64'(last_value), 64'd2);
        check_screen("t5");

        // Forced refresh under random backpressure.
        ready_mode = 1;
        step(2);
        accepts = 0;
        pulse_refresh();
        step(300);
        check("t6_force_count", 64'(accepts), 64'(count_valid()));
        check_screen("t6f");

        // Random content changes.
        for (int r = 0; r < 6; r++) begin
            ready_mode = int'($urandom_range(0, 1));
            for (int i = 0; i < 64; i++) picked[i] = 1'b0;
            exp_cnt = 0;
            accepts = 0;
            for (int k = int'($urandom_range(1, 8)); k > 0; k--) begin
                idx = int'($urandom_range(1, N));
                if (!picked[idx]) begin
                    picked[idx] = 1'b1;
                    old_c = eff(idx);
                    tb_valid[idx] = ($urandom_range(0, 3) != 0);
                    r64 = {$urandom, $urandom};
                    tb_name[idx]  = r64[39:0];
                    tb_value[idx] = $urandom;
                    if (eff(idx) != old_c) exp_cnt++;
                end
            end
            step(300);
            check($sformatf("rnd%0d_count", r), 64'(accepts), 64'(exp_cnt));
            check_screen($sformatf("rnd%0d", r));
        end

        // Reset in the middle of a refresh stream.
        ready_mode = 0;
        step(2);
        pulse_refresh();
        step(20);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_valid", 64'(upd_valid), 64'd0);
        check("t6_rst_dn", 64'(display_number), 64'd1);
        check("t6_rst_wrap", 64'(scan_wrap), 64'd0);
        clear_screen();
        @(posedge clk);
        #1;
        reset = 1'b0;
        accepts = 0;
        step(2);
        check("t6_quiet", 64'(upd_valid), 64'd0);
        step(300);
        check("t6_relearn_count", 64'(accepts), 64'(count_valid()));
        check_screen("t6r");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
